// File: rtl/pixel_burst_writer_pkg.sv
// pixel_burst_writer_pkg: shared FSM encoding and frame geometry for the frame-buffer write/read/VGA blocks.
package pixel_burst_writer_pkg;
  typedef enum logic {COLLECT = 1'b0, WRITE = 1'b1} state_t;
  localparam int PIX_W = 24;
  localparam int BURST_LEN = 8;
  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int DEF_ADDR_WIDTH = 19;
endpackage

// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer: 8-slot pixel gather buffer with fill mask; full/rd_data already reflect a same-cycle write.
module pixel_line_buffer
  import pixel_burst_writer_pkg::*;
(
  input  logic             clock,
  input  logic             neg_reset,
  input  logic             we,
  input  logic             clr,
  input  logic [2:0]       wr_slot,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [2:0]       rd_idx,
  output logic [PIX_W-1:0] rd_data,
  output logic             full
);
  logic [PIX_W-1:0] mem [BURST_LEN];
  logic [BURST_LEN-1:0] mask, hit;
  assign hit = we ? BURST_LEN'(1) << wr_slot : '0;
  assign full = &(mask | hit);
  // bypass so the first word can be presented in the same edge that captures the last pixel
  assign rd_data = (we && wr_slot == rd_idx) ? wr_data : mem[rd_idx];
  always_ff @(posedge clock)
    if (we) mem[wr_slot] <= wr_data;
  always_ff @(posedge clock or negedge neg_reset)
    if (!neg_reset) mask <= '0;
    else mask <= clr ? '0 : mask | hit;
endmodule

// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer: gathers 8 RGB pixels and writes them as a req/ack burst into the frame buffer.
// Define PIXEL_BURST_WRITER_CHECKSUM_EN to add a per-frame XOR checksum output.
module pixel_burst_writer
  import pixel_burst_writer_pkg::*;
#(
  parameter int PIXELS_PER_BURST = BURST_LEN,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                  clock,
  input  logic                  neg_reset,
  input  logic                  pix_valid,
  input  logic [7:0]            RED_values_IN,
  input  logic [7:0]            GREEN_values_IN,
  input  logic [7:0]            BLUE_values_IN,
  input  logic [2:0]            pix_slot,
  output logic                  pix_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]      mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  frame_done
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
  ,
  output logic [PIX_W-1:0]      frame_checksum
`endif
);
  state_t state, state_n;
  logic [2:0] idx, idx_n, rd_idx;
  logic [ADDR_WIDTH-1:0] base, base_n, addr_n;
  logic [PIX_W-1:0] data_n, rd_data;
  logic accept, full, ack, last, wrap, en_n, ready_n, done_n;
  assign accept = pix_valid && pix_ready;
  assign ack = mem_wr_en && mem_wr_ack;
  assign last = ack && idx == 3'(PIXELS_PER_BURST - 1);
  assign wrap = base == ADDR_WIDTH'(FRAME_PIXELS - PIXELS_PER_BURST);
  assign rd_idx = idx + {2'b0, state == WRITE};
  pixel_line_buffer u_buf (
    .clock, .neg_reset, .we(accept), .clr(last), .wr_slot(pix_slot),
    .wr_data({RED_values_IN, GREEN_values_IN, BLUE_values_IN}),
    .rd_idx, .rd_data, .full
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    base_n = base;
    en_n = 1'b0;
    addr_n = '0;
    data_n = '0;
    done_n = 1'b0;
    if (state == COLLECT) begin
      state_n = full ? WRITE : COLLECT;
      en_n = full;
      addr_n = full ? base : '0;
      data_n = full ? rd_data : '0;
    end else if (last) begin
      state_n = COLLECT;
      idx_n = '0;
      base_n = wrap ? '0 : base + ADDR_WIDTH'(PIXELS_PER_BURST);
      done_n = wrap;
    end else begin
      en_n = 1'b1;
      idx_n = ack ? idx + 3'd1 : idx;
      addr_n = ack ? mem_wr_addr + ADDR_WIDTH'(1) : mem_wr_addr;
      data_n = ack ? rd_data : mem_wr_data;
    end
    // one idle cycle after a burst before pixels are taken again
    ready_n = state == COLLECT && state_n == COLLECT;
  end
  always_ff @(posedge clock or negedge neg_reset)
    if (!neg_reset) begin
      state <= COLLECT;
      idx <= '0;
      base <= '0;
      pix_ready <= 1'b1;
      mem_wr_en <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      base <= base_n;
      pix_ready <= ready_n;
      mem_wr_en <= en_n;
      mem_wr_addr <= addr_n;
      mem_wr_data <= data_n;
      frame_done <= done_n;
    end
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
  logic [PIX_W-1:0] run_xor;
  always_ff @(posedge clock or negedge neg_reset)
    if (!neg_reset) begin
      run_xor <= '0;
      frame_checksum <= '0;
    end else if (ack) begin
      run_xor <= done_n ? '0 : run_xor ^ mem_wr_data;
      if (done_n) frame_checksum <= run_xor ^ mem_wr_data;
    end
`endif
endmodule

// File: tb/tb_pixel_burst_writer.sv
// tb_pixel_burst_writer: directed checks of pixel_burst_writer with a 16-pixel frame.
module tb_pixel_burst_writer;
  logic clock = 0, neg_reset = 0, pix_valid = 0, mem_wr_ack = 0;
  logic [7:0] red = 0, green = 0, blue = 0;
  logic [2:0] pix_slot = 0;
  logic pix_ready, mem_wr_en, frame_done;
  logic [18:0] mem_wr_addr;
  logic [23:0] mem_wr_data;
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
  logic [23:0] frame_checksum;
`endif
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = -1, ack15_cyc = -5;
  logic [18:0] wa[$];
  logic [23:0] wd[$];
  logic [23:0] exp_d[8];

  pixel_burst_writer #(.FRAME_PIXELS(16)) dut (
    .clock(clock), .neg_reset(neg_reset), .pix_valid(pix_valid),
    .RED_values_IN(red), .GREEN_values_IN(green), .BLUE_values_IN(blue),
    .pix_slot(pix_slot), .pix_ready(pix_ready), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .frame_done(frame_done)
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
    , .frame_checksum(frame_checksum)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // log every word that will be accepted on the coming edge
  always @(negedge clock) begin
    if (mem_wr_en && mem_wr_ack) begin
      wa.push_back(mem_wr_addr);
      wd.push_back(mem_wr_data);
      if (mem_wr_addr == 19'd15) ack15_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic push(input logic [2:0] s, input logic [23:0] d);
    int n = 0;
    while (!pix_ready && n < 60) begin @(posedge clock); #1; n++; end
    if (n >= 60) begin total++; bad++; $display("FAIL push_timeout waited=%0d limit=60", n); end
    pix_valid = 1; pix_slot = s; {red, green, blue} = d;
    @(posedge clock); #1;
    pix_valid = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pix_ready && n < 60) begin @(posedge clock); #1; n++; end
    if (n >= 60) begin total++; bad++; $display("FAIL ready_timeout waited=%0d limit=60", n); end
  endtask

  task automatic test_reset();
    neg_reset = 0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", pix_ready); end
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", mem_wr_en); end
    total++; if (mem_wr_addr !== 19'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_wr_addr); end
    total++; if (mem_wr_data !== 24'd0) begin bad++; $display("FAIL rst_data got=%h want=0", mem_wr_data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", frame_done); end
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
    total++; if (frame_checksum !== 24'd0) begin bad++; $display("FAIL rst_cksum got=%h want=0", frame_checksum); end
`endif
    @(negedge clock); neg_reset = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_in_order();
    int cnt = 0;
    exp_d = '{24'h000000, 24'h101010, 24'h202020, 24'h303030, 24'h404040, 24'h505050, 24'h606060, 24'h707070};
    mem_wr_ack = 1; wa.delete(); wd.delete();
    for (int s = 0; s < 8; s++) push(3'(s), exp_d[s]);
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL order_latency got=%b want=1", mem_wr_en); end
    total++; if (mem_wr_addr !== 19'd0) begin bad++; $display("FAIL order_first_addr got=%h want=0", mem_wr_addr); end
    while (!pix_ready && cnt < 60) begin cnt++; @(posedge clock); #1; end
    total++; if (cnt != 9) begin bad++; $display("FAIL order_ready_low got=%0d want=9", cnt); end
    total++; if (wa.size() != 8) begin bad++; $display("FAIL order_count got=%0d want=8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      total++; if (wa[i] !== 19'(i)) begin bad++; $display("FAIL order_addr%0d got=%h want=%h", i, wa[i], i); end
      total++; if (wd[i] !== exp_d[i]) begin bad++; $display("FAIL order_data%0d got=%h want=%h", i, wd[i], exp_d[i]); end
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL order_no_done got=%0d want=0", done_cnt); end
  endtask

  task automatic test_out_of_order();
    exp_d = '{24'hA0B0C0, 24'hA1B1C1, 24'hA2B2C2, 24'h222222, 24'hA4B4C4, 24'hA5B5C5, 24'hA6B6C6, 24'hA7B7C7};
    mem_wr_ack = 1; wa.delete(); wd.delete();
    push(7, exp_d[7]); push(3, 24'h111111); push(0, exp_d[0]); push(1, exp_d[1]);
    push(2, exp_d[2]); push(3, 24'h222222); push(6, exp_d[6]); push(5, exp_d[5]);
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL ooo_early_write got=%b want=0", mem_wr_en); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL ooo_ready_7 got=%b want=1", pix_ready); end
    push(4, exp_d[4]);
    total++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== 19'd8) begin bad++; $display("FAIL ooo_start got=%b/%h want=1/8", mem_wr_en, mem_wr_addr); end
    wait_ready();
    total++; if (wa.size() != 8) begin bad++; $display("FAIL ooo_count got=%0d want=8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      total++; if (wa[i] !== 19'(8 + i)) begin bad++; $display("FAIL ooo_addr%0d got=%h want=%h", i, wa[i], 8 + i); end
      total++; if (wd[i] !== exp_d[i]) begin bad++; $display("FAIL ooo_data%0d got=%h want=%h", i, wd[i], exp_d[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc != ack15_cyc + 1) begin bad++; $display("FAIL frame_done_time got=%0d want=%0d", done_cyc, ack15_cyc + 1); end
`ifdef PIXEL_BURST_WRITER_CHECKSUM_EN
    total++; if (frame_checksum !== 24'h8191E1) begin bad++; $display("FAIL frame_cksum got=%h want=8191e1", frame_checksum); end
`endif
  endtask

  task automatic test_delayed_ack();
    exp_d = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456, 24'h654321, 24'hABCDEF, 24'hFEDCBA, 24'h0F0F0F};
    mem_wr_ack = 0; wa.delete(); wd.delete();
    for (int s = 0; s < 8; s++) push(3'(s), exp_d[s]);
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) begin
        mem_wr_ack = (k == 3);
        @(negedge clock);
        total++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 19'(w) || mem_wr_data !== exp_d[w] || pix_ready !== 1'b0) begin
          bad++;
          $display("FAIL hold_w%0d_k%0d got=%b/%h/%h/%b want=1/%h/%h/0", w, k, mem_wr_en, mem_wr_addr, mem_wr_data, pix_ready, w, exp_d[w]);
        end
        @(posedge clock); #1;
      end
      mem_wr_ack = 0;
    end
    wait_ready();
    total++; if (wa.size() != 8) begin bad++; $display("FAIL hold_count got=%0d want=8", wa.size()); end
  endtask

  task automatic test_reset_mid_burst();
    mem_wr_ack = 1;
    for (int s = 0; s < 8; s++) push(3'(s), exp_d[s]);
    repeat (4) @(posedge clock);
    #1;
    total++; if (mem_wr_addr !== 19'd12) begin bad++; $display("FAIL mid_idx4 got=%h want=c", mem_wr_addr); end
    neg_reset = 0;
    #1;
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL mid_async_en got=%b want=0", mem_wr_en); end
    total++; if (mem_wr_addr !== 19'd0) begin bad++; $display("FAIL mid_async_addr got=%h want=0", mem_wr_addr); end
    @(negedge clock); neg_reset = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_hold_valid();
    int n = 0;
    exp_d = '{24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C, 24'h3A3B3C, 24'h4A4B4C, 24'h5A5B5C, 24'h6A6B6C, 24'h7A7B7C};
    mem_wr_ack = 1; wa.delete(); wd.delete();
    for (int s = 0; s < 8; s++) push(3'(s), exp_d[s]);
    while (!pix_ready && n < 60) begin
      pix_valid = 1; pix_slot = 3'(n); {red, green, blue} = 24'($urandom);
      @(posedge clock); #1; n++;
    end
    pix_valid = 0;
    total++; if (wa.size() != 8) begin bad++; $display("FAIL after_rst_count got=%0d want=8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      total++; if (wa[i] !== 19'(i)) begin bad++; $display("FAIL after_rst_addr%0d got=%h want=%h", i, wa[i], i); end
      total++; if (wd[i] !== exp_d[i]) begin bad++; $display("FAIL valid_ignored_data%0d got=%h want=%h", i, wd[i], exp_d[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL done_total got=%0d want=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_delayed_ack();
    test_reset_mid_burst();
    test_hold_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
